alu_arbiter: RTL and testbench

//  Shares the single 16-bit ALU between two requesters (req0: execute-stage ops, req1: PC/address

---
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU: grants one request, drives the ALU
// inputs from registers, waits ALU_LAT cycles and returns a registered, id-tagged response.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module alu_arbiter #(
    parameter int WIDTH   = 16,
    parameter int OP_W    = 2,
    parameter int FUNC_W  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [OP_W-1:0]   req0_aluop,
    input  logic [FUNC_W-1:0] req0_func,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [OP_W-1:0]   req1_aluop,
    input  logic [FUNC_W-1:0] req1_func,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [WIDTH-1:0]  resp_result,
    output logic              resp_zero,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    logic [1:0]        state_r;
    logic              last_grant_r;
    logic              grant_id_r;
    logic [3:0]        lat_cnt_r;
    logic [WIDTH-1:0]  alu_a_r;
    logic [WIDTH-1:0]  alu_b_r;
    logic [OP_W-1:0]   alu_op_r;
    logic [FUNC_W-1:0] alu_func_r;
    logic              resp_valid_r;
    logic              resp_id_r;
    logic [WIDTH-1:0]  resp_result_r;
    logic              resp_zero_r;

    logic              grant1_s;
    logic              ready0_s;
    logic              ready1_s;
    logic [WIDTH-1:0]  sel_a_s;
    logic [WIDTH-1:0]  sel_b_s;
    logic [OP_W-1:0]   sel_op_s;
    logic [FUNC_W-1:0] sel_func_s;

    // Grant decision: which requester wins if it is (or both are) valid
    always_comb begin
        grant1_s = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (req1_valid && !req0_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant1_s = 1'b0;
        end
`else
        if (req0_valid && req1_valid) begin
            grant1_s = (last_grant_r == 1'b0);
        end else begin
            grant1_s = req1_valid;
        end
`endif
    end

    // Handshake readies and operand select for the granted requester
    always_comb begin
        ready0_s   = 1'b0;
        ready1_s   = 1'b0;
        sel_a_s    = req0_a;
        sel_b_s    = req0_b;
        sel_op_s   = req0_aluop;
        sel_func_s = req0_func;
        if (state_r == IDLE) begin
            ready0_s = req0_valid && !grant1_s;
            ready1_s = req1_valid && grant1_s;
        end else begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end
        if (grant1_s) begin
            sel_a_s    = req1_a;
            sel_b_s    = req1_b;
            sel_op_s   = req1_aluop;
            sel_func_s = req1_func;
        end else begin
            sel_a_s    = req0_a;
            sel_b_s    = req0_b;
            sel_op_s   = req0_aluop;
            sel_func_s = req0_func;
        end
    end

    // Control FSM, ALU operand registers and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            last_grant_r  <= 1'b1;
            grant_id_r    <= 1'b0;
            lat_cnt_r     <= 4'd0;
            alu_a_r       <= '0;
            alu_b_r       <= '0;
            alu_op_r      <= '0;
            alu_func_r    <= '0;
            resp_valid_r  <= 1'b0;
            resp_id_r     <= 1'b0;
            resp_result_r <= '0;
            resp_zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ready0_s || ready1_s) begin
                        alu_a_r      <= sel_a_s;
                        alu_b_r      <= sel_b_s;
                        alu_op_r     <= sel_op_s;
                        alu_func_r   <= sel_func_s;
                        grant_id_r   <= ready1_s;
                        last_grant_r <= ready1_s;
                        lat_cnt_r    <= LAT_LOAD;
                        state_r      <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (lat_cnt_r == 4'd0) begin
                        resp_result_r <= alu_result;
                        resp_zero_r   <= alu_zero;
                        resp_id_r     <= grant_id_r;
                        resp_valid_r  <= 1'b1;
                        state_r       <= RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = ready0_s;
    assign req1_ready  = ready1_s;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign alu_op      = alu_op_r;
    assign alu_func    = alu_func_r;
    assign resp_valid  = resp_valid_r;
    assign resp_id     = resp_id_r;
    assign resp_result = resp_result_r;
    assign resp_zero   = resp_zero_r;
    assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one ALU_LAT=1 instance and one ALU_LAT=3 instance, each
// fed by an adder stub (result=a+b, zero=(result==0)).
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = 16'd0, req0_b = 16'd0, req1_a = 16'd0, req1_b = 16'd0;
    logic [1:0]  req0_aluop = 2'd0, req1_aluop = 2'd0;
    logic [7:0]  req0_func = 8'd0, req1_func = 8'd0;
    logic [15:0] alu_a, alu_b, alu_result, resp_result;
    logic [1:0]  alu_op;
    logic [7:0]  alu_func;
    logic        alu_zero, resp_valid, resp_id, resp_zero, busy;
    logic        resp_ready = 1'b0;

    logic        req0_valid3 = 1'b0;
    logic        req0_ready3, req1_ready3;
    logic [15:0] alu_a3, alu_b3, alu_result3, resp_result3;
    logic [1:0]  alu_op3;
    logic [7:0]  alu_func3;
    logic        alu_zero3, resp_valid3, resp_id3, resp_zero3, busy3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign alu_result  = alu_a + alu_b;
    assign alu_zero    = (alu_result == 16'd0);
    assign alu_result3 = alu_a3 + alu_b3;
    assign alu_zero3   = (alu_result3 == 16'd0);

    alu_arbiter #(.WIDTH(16), .OP_W(2), .FUNC_W(8), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_aluop(req0_aluop), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_aluop(req1_aluop), .req1_func(req1_func),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_func(alu_func),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .busy(busy)
    );

    alu_arbiter #(.WIDTH(16), .OP_W(2), .FUNC_W(8), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid3), .req0_ready(req0_ready3), .req0_a(req0_a), .req0_b(req0_b),
        .req0_aluop(req0_aluop), .req0_func(req0_func),
        .req1_valid(1'b0), .req1_ready(req1_ready3), .req1_a(req1_a), .req1_b(req1_b),
        .req1_aluop(req1_aluop), .req1_func(req1_func),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_func(alu_func3),
        .alu_result(alu_result3), .alu_zero(alu_zero3),
        .resp_valid(resp_valid3), .resp_ready(1'b1), .resp_id(resp_id3),
        .resp_result(resp_result3), .resp_zero(resp_zero3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_g;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_alu_a", alu_a, 16'd0);
        check("rst_resp_result", resp_result, 16'd0);
        rst = 1'b0;
        tick();

        // Single req0 op, response held with resp_ready low for 5 cycles
        req0_a = 16'd3; req0_b = 16'd2; req0_aluop = 2'b00; req0_func = 8'h08;
        req0_valid = 1'b1;
        #1;
        check("t2_ready0", req0_ready, 1'b1);
        check("t2_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        check("t2_alu_a", alu_a, 16'd3);
        check("t2_alu_op", alu_op, 2'b00);
        check("t2_alu_func", alu_func, 8'h08);
        check("t2_busy", busy, 1'b1);
        check("t2_resp_early", resp_valid, 1'b0);
        tick();
        check("t2_resp_valid", resp_valid, 1'b1);
        check("t2_resp_id", resp_id, 1'b0);
        check("t2_resp_result", resp_result, 16'd5);
        check("t2_resp_zero", resp_zero, 1'b0);

        req1_a = 16'hFFFF; req1_b = 16'h0001; req1_aluop = 2'b01; req1_func = 8'h10;
        req1_valid = 1'b1;
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_resp_valid", resp_valid, 1'b1);
            check("t5_resp_result", resp_result, 16'd5);
            check("t5_ready0", req0_ready, 1'b0);
            check("t5_ready1", req1_ready, 1'b0);
            check("t5_busy", busy, 1'b1);
            tick();
        end
        req0_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("t5_resp_drop", resp_valid, 1'b0);
        check("t5_idle", busy, 1'b0);
        check("t5_alu_hold", alu_a, 16'd3);

        // req1 wrap-around to zero
        #1;
        check("t4_ready1", req1_ready, 1'b1);
        check("t4_ready0", req0_ready, 1'b0);
        tick();
        req1_valid = 1'b0;
        check("t4_alu_a", alu_a, 16'hFFFF);
        check("t4_alu_op", alu_op, 2'b01);
        tick();
        check("t4_resp_valid", resp_valid, 1'b1);
        check("t4_resp_result", resp_result, 16'h0000);
        check("t4_resp_zero", resp_zero, 1'b1);
        check("t4_resp_id", resp_id, 1'b1);
        tick();

        // Both valid, four back-to-back ops
        req0_a = 16'd10;  req0_b = 16'd20; req0_aluop = 2'b00; req0_func = 8'h00;
        req1_a = 16'd100; req1_b = 16'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = i[0];
`endif
            #1;
            check("t3_ready0", req0_ready, !exp_g);
            check("t3_ready1", req1_ready, exp_g);
            tick();
            tick();
            check("t3_resp_id", resp_id, exp_g);
            check("t3_resp_result", resp_result, exp_g ? 16'd101 : 16'd30);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Reset in the middle of EXEC
        req0_a = 16'd7; req0_b = 16'd7; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        check("t1_busy_exec", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t1_busy", busy, 1'b0);
        check("t1_resp_valid", resp_valid, 1'b0);
        check("t1_alu_a", alu_a, 16'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_no_resp", resp_valid, 1'b0);
            check("t1_stay_idle", busy, 1'b0);
        end

        // ALU_LAT=3 instance
        req0_a = 16'd3; req0_b = 16'd2; req0_aluop = 2'b11; req0_func = 8'h20;
        req0_valid3 = 1'b1;
        #1;
        check("t6_ready0", req0_ready3, 1'b1);
        tick();
        req0_valid3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_alu_a", alu_a3, 16'd3);
            check("t6_alu_op", alu_op3, 2'b11);
            check("t6_alu_func", alu_func3, 8'h20);
            check("t6_resp_early", resp_valid3, 1'b0);
            tick();
        end
        check("t6_resp_valid", resp_valid3, 1'b1);
        check("t6_resp_result", resp_result3, 16'd5);
        check("t6_resp_id", resp_id3, 1'b0);
        tick();
        check("t6_idle", busy3, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
